// File: rtl/lnic_pkg.sv
// Shared beat-format constants and the receive-side FSM state type.
package lnic_pkg;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    // One stored entry holds {last, keep, data}.
    localparam int BEAT_W = DATA_W + KEEP_W + 1;

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } rx_state_e;

endpackage

// File: rtl/net_rx_buffer_ram.sv
// Packet storage: one synchronous write port and one asynchronous read port.
module net_rx_buffer_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 73
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // Store an accepted inbound beat; contents are never cleared.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/net_rx_buffer.sv
// Store-and-forward receive buffer: a packet becomes visible to the consumer
// only after its last beat has been written. A packet that runs out of space
// is rolled back to the last commit point and the rest of it is discarded.
module net_rx_buffer
    import lnic_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              net_in_valid,
    input  logic [DATA_W-1:0] net_in_bits_data,
    input  logic [KEEP_W-1:0] net_in_bits_keep,
    input  logic              net_in_bits_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    output logic [CNT_W-1:0]  drop_count,
    output logic [CNT_W-1:0]  pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_cm_ptr;
    logic [PW-1:0]    r_rd_ptr;
    rx_state_e        r_state;
    logic [CNT_W-1:0] r_drop_count;
    logic [CNT_W-1:0] r_pkt_count;

    logic [PW-1:0]     w_used;
    logic              w_has_space;
    logic              w_write;
    logic              w_read;
    logic [BEAT_W-1:0] w_rd_entry;

    // Occupancy counts uncommitted beats too, and uses registered pointers only,
    // so a read in the same cycle never frees room for the current write.
    assign w_used      = r_wr_ptr - r_rd_ptr;
    assign w_has_space = (w_used != DEPTH_P);
    assign w_write     = !reset && net_in_valid && (r_state == ST_ACCEPT) && w_has_space;
    assign w_read      = out_valid && out_ready;

    net_rx_buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (BEAT_W)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_write),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata ({net_in_bits_last, net_in_bits_keep, net_in_bits_data}),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rd_entry)
    );

    assign out_valid  = !reset && (r_rd_ptr != r_cm_ptr);
    assign out_data   = w_rd_entry[DATA_W-1:0];
    assign out_keep   = w_rd_entry[DATA_W +: KEEP_W];
    assign out_last   = w_rd_entry[BEAT_W-1];
    assign drop_count = r_drop_count;
    assign pkt_count  = r_pkt_count;

    // Pointer, inbound FSM and counter updates.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_cm_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_state      <= ST_ACCEPT;
            r_drop_count <= '0;
            r_pkt_count  <= '0;
        end else begin
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (net_in_valid) begin
                case (r_state)
                    ST_ACCEPT: begin
                        if (w_has_space) begin
                            r_wr_ptr <= r_wr_ptr + PW'(1);
                            if (net_in_bits_last) begin
                                r_cm_ptr <= r_wr_ptr + PW'(1);
                                if (r_pkt_count != '1) begin
                                    r_pkt_count <= r_pkt_count + CNT_W'(1);
                                end
                            end
                        end else begin
                            // Out of room: roll back the partial packet.
                            r_wr_ptr <= r_cm_ptr;
                            if (r_drop_count != '1) begin
                                r_drop_count <= r_drop_count + CNT_W'(1);
                            end
                            if (!net_in_bits_last) begin
                                r_state <= ST_DROP;
                            end
                        end
                    end
                    ST_DROP: begin
                        if (net_in_bits_last) begin
                            r_state <= ST_ACCEPT;
                        end
                    end
                    default: r_state <= ST_ACCEPT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_net_rx_buffer.sv
// Directed scenarios plus a random phase, checked every cycle against a
// queue-based model of the buffer.
module tb_net_rx_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        net_in_valid;
    logic [63:0] net_in_bits_data;
    logic [7:0]  net_in_bits_keep;
    logic        net_in_bits_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_last;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W-1:0] pkt_count;

    net_rx_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .net_in_valid     (net_in_valid),
        .net_in_bits_data (net_in_bits_data),
        .net_in_bits_keep (net_in_bits_keep),
        .net_in_bits_last (net_in_bits_last),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_keep         (out_keep),
        .out_last         (out_last),
        .drop_count       (drop_count),
        .pkt_count        (pkt_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    // Model: committed beats awaiting the consumer, and the packet in flight.
    beat_t m_out[$];
    beat_t m_pend[$];
    bit    m_dropping;
    int    m_drops;
    int    m_pkts;
    int    n_xfer;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model on every rising edge using the inputs held for that cycle.
    always @(posedge clock) begin : model
        int free;
        free = DEPTH - (m_out.size() + m_pend.size());
        if (reset) begin
            m_out.delete();
            m_pend.delete();
            m_dropping = 1'b0;
            m_drops    = 0;
            m_pkts     = 0;
        end else begin
            if (m_out.size() > 0 && out_ready) begin
                void'(m_out.pop_front());
                n_xfer++;
            end
            if (net_in_valid) begin
                if (m_dropping) begin
                    if (net_in_bits_last) m_dropping = 1'b0;
                end else if (free > 0) begin
                    m_pend.push_back('{net_in_bits_data, net_in_bits_keep, net_in_bits_last});
                    if (net_in_bits_last) begin
                        foreach (m_pend[i]) m_out.push_back(m_pend[i]);
                        m_pend.delete();
                        m_pkts++;
                    end
                end else begin
                    m_pend.delete();
                    m_drops++;
                    if (!net_in_bits_last) m_dropping = 1'b1;
                end
            end
        end
    end

    // Compare DUT outputs with the model mid-cycle.
    always @(negedge clock) begin
        bit exp_valid;
        exp_valid = !reset && (m_out.size() > 0);
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            chk("out_data", out_data, m_out[0].d);
            chk("out_keep", 64'(out_keep), 64'(m_out[0].k));
            chk("out_last", 64'(out_last), 64'(m_out[0].l));
        end
        chk("drop_count", 64'(drop_count), 64'(m_drops));
        chk("pkt_count", 64'(pkt_count), 64'(m_pkts));
    end

    task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] k, input logic l);
        net_in_valid     = v;
        net_in_bits_data = d;
        net_in_bits_keep = k;
        net_in_bits_last = l;
        @(posedge clock);
        #1;
        net_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_pkt(input int len, input logic [7:0] last_keep);
        for (int i = 0; i < len; i++) begin
            drive(1'b1, {$urandom, $urandom}, (i == len - 1) ? last_keep : 8'hFF, i == len - 1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    int base;

    initial begin
        reset            = 1'b1;
        net_in_valid     = 1'b0;
        net_in_bits_data = '0;
        net_in_bits_keep = '0;
        net_in_bits_last = 1'b0;
        out_ready        = 1'b0;
        n_xfer           = 0;
        idle(3);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_drop", 64'(drop_count), 64'd0);
        chk("reset_pkt", 64'(pkt_count), 64'd0);
        reset = 1'b0;

        // Three-beat packet with ready held high.
        out_ready = 1'b1;
        base = n_xfer;
        drive(1'b1, 64'h1111_2222_3333_4444, 8'hFF, 1'b0);
        drive(1'b1, 64'h5555_6666_7777_8888, 8'hFF, 1'b0);
        chk("pre_commit_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 64'h9999_AAAA_BBBB_CCCC, 8'h0F, 1'b1);
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("latency_data", out_data, 64'h1111_2222_3333_4444);
        idle(4);
        chk("p3_beats", 64'(n_xfer - base), 64'd3);
        chk("p3_pkt", 64'(pkt_count), 64'd1);

        // Full buffer: second packet is dropped, first retained.
        do_reset();
        out_ready = 1'b0;
        send_pkt(6, 8'h3F);
        send_pkt(4, 8'h01);
        idle(2);
        chk("full_drop", 64'(drop_count), 64'd1);
        chk("full_pkt", 64'(pkt_count), 64'd1);
        base = n_xfer;
        out_ready = 1'b1;
        idle(10);
        chk("full_drain", 64'(n_xfer - base), 64'd6);

        // Oversized packet always dropped, exactly once.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, {$urandom, $urandom}, 8'hFF, i == 9);
            chk("long_valid", 64'(out_valid), 64'd0);
        end
        chk("long_drop", 64'(drop_count), 64'd1);
        base = n_xfer;
        send_pkt(2, 8'h07);
        idle(4);
        chk("after_long_beats", 64'(n_xfer - base), 64'd2);
        chk("after_long_pkt", 64'(pkt_count), 64'd1);

        // Back-to-back single-beat packets.
        do_reset();
        base = n_xfer;
        for (int i = 0; i < 100; i++) send_pkt(1, 8'(i));
        idle(3);
        chk("stream_drop", 64'(drop_count), 64'd0);
        chk("stream_pkt", 64'(pkt_count), 64'd100);
        chk("stream_beats", 64'(n_xfer - base), 64'd100);

        // Reset mid-packet with a committed packet buffered.
        do_reset();
        out_ready = 1'b0;
        send_pkt(2, 8'hFF);
        drive(1'b1, 64'hDEAD, 8'hFF, 1'b0);
        drive(1'b1, 64'hBEEF, 8'hFF, 1'b0);
        reset = 1'b1;
        drive(1'b1, 64'hCAFE, 8'hFF, 1'b1);
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_drop", 64'(drop_count), 64'd0);
        chk("rst_mid_pkt", 64'(pkt_count), 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        base = n_xfer;
        drive(1'b1, 64'h0123_4567_89AB_CDEF, 8'h81, 1'b1);
        idle(3);
        chk("rst_fresh_beats", 64'(n_xfer - base), 64'd1);
        chk("rst_fresh_pkt", 64'(pkt_count), 64'd1);

        // Drain two packets with toggling ready.
        do_reset();
        out_ready = 1'b0;
        send_pkt(3, 8'h0F);
        send_pkt(2, 8'hF0);
        base = n_xfer;
        for (int i = 0; i < 12; i++) begin
            out_ready = (i % 2 == 0);
            idle(1);
        end
        chk("toggle_beats", 64'(n_xfer - base), 64'd5);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 2) != 0, {$urandom, $urandom}, 8'($urandom),
                  $urandom_range(0, 4) == 0);
        end
        out_ready = 1'b1;
        idle(DEPTH + 4);
        chk("random_drained", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
